// File: rtl/reg_file_sweep.sv
// rtl/reg_file_sweep.sv - 8x8 register file with a post-reset clear sweep and dual combinational read ports.
// Optional macro REG_FILE_BYPASS_EN adds write-first forwarding from IN to the read ports.
module reg_file_sweep (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] IN,
    input  logic [2:0] INADDRESS,
    input  logic       WRITE,
    input  logic [2:0] OUT1ADDRESS,
    input  logic [2:0] OUT2ADDRESS,
    output logic [7:0] OUT1,
    output logic [7:0] OUT2,
    output logic       BUSY
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] swp;
    logic [2:0] swp_next;
    logic       clr_en;
    logic       wr_en;
    logic [7:0] regs [8];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= CLEAR;
            swp   <= 3'd0;
            BUSY  <= 1'b1;
        end else begin
            state <= state_next;
            swp   <= swp_next;
            BUSY  <= (state_next == CLEAR);
        end
    end

    // The counter parks at 7 on the last clear edge so it never wraps in READY.
    always_comb begin
        state_next = state;
        swp_next   = swp;
        clr_en     = 1'b0;
        wr_en      = 1'b0;
        if (!RESET) begin
            case (state)
                CLEAR: begin
                    clr_en = 1'b1;
                    if (swp == 3'd7) begin
                        state_next = READY;
                    end else begin
                        swp_next = swp + 3'd1;
                    end
                end
                READY: begin
                    wr_en = WRITE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_en) begin
            regs[swp] <= 8'h00;
        end else if (wr_en) begin
            regs[INADDRESS] <= IN;
        end
    end

    // Forwarding keys off wr_en so it only shows data that will actually commit.
    always_comb begin
        OUT1 = 8'h00;
        OUT2 = 8'h00;
        if (!BUSY) begin
            OUT1 = regs[OUT1ADDRESS];
            OUT2 = regs[OUT2ADDRESS];
`ifdef REG_FILE_BYPASS_EN
            if (wr_en && (OUT1ADDRESS == INADDRESS)) begin
                OUT1 = IN;
            end
            if (wr_en && (OUT2ADDRESS == INADDRESS)) begin
                OUT2 = IN;
            end
`else
`endif
        end
    end

endmodule

// File: doc/reg_file_sweep.md
REG_FILE_SWEEP -- requirements
Module: reg_file_sweep

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CLK and RESET as elsewhere in the codebase.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  synchronous active-high reset; starts the clear sweep.
REQ-004 IN  input  8  write data from the ALU result path.
REQ-005 INADDRESS  input  3  write register index.
REQ-006 WRITE  input  1  write enable, sampled at the CLK rising edge.
REQ-007 OUT1ADDRESS  input  3  read port 1 index.
REQ-008 OUT2ADDRESS  input  3  read port 2 index.
REQ-009 OUT1  output  8  read port 1 data, ALU operand A.
REQ-010 OUT2  output  8  read port 2 data, operand B; feeds the two's-complement converter for SUB/branch compare.
REQ-011 BUSY  output  1  registered; high while the clear sweep runs.

Function
REQ-012 Storage SHALL be 8 registers x 8 bits; register 0 SHALL be writable, not hardwired to zero.
REQ-013 The FSM SHALL have two states: CLEAR (BUSY=1) and READY (BUSY=0), plus a 3-bit sweep counter SWP.
REQ-014 While RESET=1 at an edge: state -> CLEAR, SWP -> 0, no register modified.
REQ-015 In CLEAR with RESET=0, each edge SHALL zero reg[SWP] and increment SWP; the edge that clears reg[7] SHALL move the state to READY.
REQ-016 BUSY SHALL therefore fall exactly 8 edges after the first edge with RESET=0.
REQ-017 Reads SHALL be combinational with no added delay: OUTn = 0 while BUSY=1, else reg[OUTnADDRESS].
REQ-018 In READY, WRITE=1 at an edge SHALL store IN into reg[INADDRESS]; the new value SHALL be visible on the read ports after that edge.
REQ-019 WRITE=1 while BUSY=1 or RESET=1 SHALL be dropped silently: no store, no queuing.
REQ-020 Both read ports SHALL be able to address the same register, including the register being written, with no interference.
REQ-021 RESET asserted mid-sweep or in READY SHALL restart the sweep from SWP=0, with BUSY=1 from the next edge.
REQ-022 SWP SHALL NOT wrap back to 0 in READY; it SHALL hold until the next reset.
REQ-023 X or Z on an unused address SHALL NOT corrupt stored registers when WRITE=0.

Reset
REQ-024 Reset values: state=CLEAR, SWP=0, BUSY=1; OUT1 and OUT2 read 0 throughout reset and the sweep.
REQ-025 Register contents SHALL be guaranteed 0 only after BUSY falls; reset SHALL NOT clear registers combinationally.

Configuration
REQ-026 Macro REG_FILE_BYPASS_EN: when defined, in READY with WRITE=1 and OUTnADDRESS==INADDRESS, OUTn SHALL return IN combinationally in the same cycle (write-first forwarding).
REQ-027 When REG_FILE_BYPASS_EN is undefined, OUTn SHALL return the pre-write content until the write edge.
REQ-028 Forwarding SHALL never apply while BUSY=1; OUTn SHALL stay 0.

Verification
REQ-029 Sweep timing: assert RESET for 2 cycles, then release -> BUSY=1 for exactly 8 edges, then 0; all 8 registers read 0.
REQ-030 Write/read: write 0x05 to r2 and 0xFB to r3, then read OUT1=r2 and OUT2=r3 -> 0x05 and 0xFB.
REQ-031 Busy drop: WRITE=1, INADDRESS=4, IN=0x7F during sweep cycle 3 -> r4 reads 0x00 after BUSY falls.
REQ-032 Mid-sweep reset: r1=0xAA before reset, pulse RESET at sweep cycle 5 -> BUSY stays high 8 more edges after release; r1 reads 0x00.
REQ-033 Same-cycle hazard: r6=0x10, then WRITE IN=0x20 to r6 with OUT2ADDRESS=6 -> before the edge, OUT2=0x20 with REG_FILE_BYPASS_EN and 0x10 without; after the edge, 0x20 in both builds.
REQ-034 Dual-port alias: OUT1ADDRESS=OUT2ADDRESS=0 with r0=0x80 -> both ports read 0x80.
